// File: rtl/mult_temporal_signed_unsigned.sv
// ---------------------------------------------------------------------------
// mult_temporal_signed_unsigned
//
// Multi-cycle signed/unsigned multiplier. Operand in_1 is consumed one
// BRICK_WIDTH-bit brick per cycle; each cycle adds (in_0 x brick) << (k*B)
// into an accumulator, so only an (IN_0_WIDTH+1) x (BRICK_WIDTH+1) multiplier
// array is needed. Valid/ready handshakes on both the operand and result side.
//
// Optional feature macro: MULT_TEMPORAL_ACC_EN
//   When defined, an acc_clear port exists and is sampled at accept. If
//   acc_clear=0, the accumulator keeps the previous result, so out becomes the
//   running sum of products (mod 2^OUT_WIDTH). When the macro is undefined,
//   the accumulator is always cleared at accept.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  operands can be accepted (combinational from state/out_ready)
//   in_0       in   multiplicand, IN_0_WIDTH bits
//   in_1       in   multiplier, IN_1_WIDTH bits, split into bricks
//   sign_mode  in   bit0: in_0 signed, bit1: in_1 signed
//   acc_clear  in   clear accumulator at accept (MULT_TEMPORAL_ACC_EN only)
//   out_valid  out  result valid (registered)
//   out_ready  in   downstream accepts result
//   out        out  product / running sum, OUT_WIDTH bits (registered)
// ---------------------------------------------------------------------------
module mult_temporal_signed_unsigned #(
    parameter int unsigned IN_0_WIDTH  = 8,
    parameter int unsigned IN_1_WIDTH  = 8,
    parameter int unsigned BRICK_WIDTH = 2,
    parameter int unsigned OUT_WIDTH   = IN_0_WIDTH + IN_1_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_0_WIDTH-1:0]   in_0,
    input  logic [IN_1_WIDTH-1:0]   in_1,
    input  logic [1:0]              sign_mode,
`ifdef MULT_TEMPORAL_ACC_EN
    input  logic                    acc_clear,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out
);

    localparam int unsigned NUM_BRICKS = IN_1_WIDTH / BRICK_WIDTH;
    localparam int unsigned K_W        = $clog2(NUM_BRICKS + 1);
    localparam int unsigned SH_W       = $clog2(IN_1_WIDTH + 1) + 1;
    localparam int unsigned PP_W       = IN_0_WIDTH + BRICK_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [IN_0_WIDTH-1:0]   a_q, a_d;
    logic [IN_1_WIDTH-1:0]   b_q, b_d;
    logic [1:0]              mode_q, mode_d;
    logic [OUT_WIDTH-1:0]    acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;

    logic                    accept;
    logic                    clear_at_accept;
    logic                    last_brick;
    logic [BRICK_WIDTH-1:0]  brick;
    logic signed [IN_0_WIDTH:0]  ext0;
    logic signed [BRICK_WIDTH:0] extb;
    logic signed [PP_W-1:0]  pp;
    logic [OUT_WIDTH-1:0]    pp_ext;
    logic [SH_W-1:0]         shamt;
    logic [OUT_WIDTH-1:0]    pp_shift;

    // Operand handshake: free in IDLE, or in DONE when the result leaves this cycle
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef MULT_TEMPORAL_ACC_EN
    assign clear_at_accept = acc_clear;
`else
    assign clear_at_accept = 1'b1;
`endif

    // b_q is shifted right each BUSY cycle, so the current brick is always the LSBs
    assign brick      = b_q[BRICK_WIDTH-1:0];
    assign last_brick = (k_q == K_W'(NUM_BRICKS - 1));

    // Only the top brick carries the sign of in_1; lower bricks are magnitudes
    assign ext0 = {mode_q[0] & a_q[IN_0_WIDTH-1], a_q};
    assign extb = {last_brick & mode_q[1] & brick[BRICK_WIDTH-1], brick};

    // Signed x signed product of the extended operands is exact in PP_W bits
    assign pp       = PP_W'(ext0) * PP_W'(extb);
    assign pp_ext   = OUT_WIDTH'(pp);
    assign shamt    = SH_W'(k_q) * SH_W'(BRICK_WIDTH);
    assign pp_shift = pp_ext << shamt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            BUSY: begin
                acc_d = acc_q + pp_shift;
                b_d   = b_q >> BRICK_WIDTH;
                k_d   = k_q + K_W'(1);
                if (last_brick) begin
                    state_d     = DONE;
                    k_d         = '0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept overrides IDLE hold and the DONE->IDLE return
        if (accept) begin
            state_d     = BUSY;
            out_valid_d = 1'b0;
            k_d         = '0;
            a_d         = in_0;
            b_d         = in_1;
            mode_d      = sign_mode;
            acc_d       = clear_at_accept ? '0 : acc_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = acc_q;

endmodule

// File: tb/tb_mult_temporal_signed_unsigned.sv
// Directed testbench for mult_temporal_signed_unsigned at default parameters.
module tb_mult_temporal_signed_unsigned;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_0;
    logic [7:0]  in_1;
    logic [1:0]  sign_mode;
`ifdef MULT_TEMPORAL_ACC_EN
    logic        acc_clear;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out;

    int checks;
    int errors;

    mult_temporal_signed_unsigned dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_0      (in_0),
        .in_1      (in_1),
        .sign_mode (sign_mode),
`ifdef MULT_TEMPORAL_ACC_EN
        .acc_clear (acc_clear),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; lat counts edges from the accept edge (inclusive)
    task automatic wait_result(input string tag, input logic [16:0] exp);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check_eq({tag, "_lat"}, 32'(lat), 32'd5);
        check_eq({tag, "_out"}, 32'(out), 32'(exp));
    endtask

    // One full transaction; in_valid stays high with junk during BUSY to prove it is ignored
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] m, input logic clr, input logic [16:0] exp);
        in_0      = a;
        in_1      = b;
        sign_mode = m;
`ifdef MULT_TEMPORAL_ACC_EN
        acc_clear = clr;
`else
        if (clr) begin
            in_valid = 1'b1;
        end
`endif
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_0      = ~a;
        in_1      = ~b;
        sign_mode = ~m;
        wait_result(tag, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_0      = '0;
        in_1      = '0;
        sign_mode = '0;
        out_ready = 1'b0;
`ifdef MULT_TEMPORAL_ACC_EN
        acc_clear = 1'b1;
`endif
        tick();
        tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();

        run_op("uxu_ff",   8'hFF, 8'hFF, 2'd0, 1'b1, 17'h0FE01);
        run_op("sxs_8080", 8'h80, 8'h80, 2'd3, 1'b1, 17'h04000);
        run_op("sxs_807f", 8'h80, 8'h7F, 2'd3, 1'b1, 17'h1C080);
        run_op("sxu_ff",   8'hFF, 8'hFF, 2'd1, 1'b1, 17'h1FF01);
        run_op("uxs_ff",   8'hFF, 8'hFF, 2'd2, 1'b1, 17'h1FF01);
        run_op("sxs_m1m1", 8'hFF, 8'hFF, 2'd3, 1'b1, 17'h00001);
        run_op("uxs_7f80", 8'h7F, 8'h80, 2'd2, 1'b1, 17'h1C080);

        // Backpressure: 0x12 x 0x34 = 936, then hold result while a new op waits
        in_0 = 8'h12; in_1 = 8'h34; sign_mode = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_0 = 8'd7; in_1 = 8'd9; sign_mode = 2'd0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("bp_lat", 32'(lat), 32'd5);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_hold_out", 32'(out), 32'h3A8);
            check_eq("bp_hold_vld", 32'(out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_rel", 32'(in_ready), 32'd1);
        tick();
        out_ready = 1'b0;
        in_0 = 8'h00; in_1 = 8'h00;
        check_eq("bp_vld_after", 32'(out_valid), 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check_eq("bp2_lat", 32'(lat), 32'd5);
        check_eq("bp2_out", 32'(out), 32'd63);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-BUSY with k=2
        in_0 = 8'hFF; in_1 = 8'hFF; sign_mode = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_vld", 32'(out_valid), 32'd0);
        check_eq("midrst_out", 32'(out), 32'd0);
        check_eq("midrst_rdy", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();
        run_op("post_rst", 8'd3, 8'd4, 2'd0, 1'b1, 17'd12);

`ifdef MULT_TEMPORAL_ACC_EN
        run_op("acc_clr1", 8'd3,  8'd4, 2'd0, 1'b1, 17'd12);
        run_op("acc_clr0", 8'd3,  8'd4, 2'd0, 1'b0, 17'd24);
        run_op("acc_neg",  8'hFF, 8'd1, 2'd3, 1'b0, 17'd23);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
